cpu_core: RTL



---
 rtl/cpu_pkg.sv | 87 ++++++++
 rtl/cpu_alu.sv | 29 ++
 rtl/cpu_core.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, FSM states, status bits and decode helpers for cpu_core (INDEX state only with CPU_INDEXED_MODES_EN)
package cpu_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_SBC_IMM = 8'hE9;
    localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
    localparam logic [7:0] OP_LDX_ZP  = 8'hA6;
    localparam logic [7:0] OP_LDY_ZP  = 8'hA4;
    localparam logic [7:0] OP_ADC_ZP  = 8'h65;
    localparam logic [7:0] OP_STA_ZP  = 8'h85;
    localparam logic [7:0] OP_STX_ZP  = 8'h86;
    localparam logic [7:0] OP_STY_ZP  = 8'h84;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_LDA_ZPX = 8'hB5;
    localparam logic [7:0] OP_STA_ZPX = 8'h95;
    localparam logic [7:0] OP_LDX_ZPY = 8'hB6;
    localparam logic [7:0] OP_TAX     = 8'hAA;
    localparam logic [7:0] OP_TAY     = 8'hA8;
    localparam logic [7:0] OP_TXA     = 8'h8A;
    localparam logic [7:0] OP_TYA     = 8'h98;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_INY     = 8'hC8;
    localparam logic [7:0] OP_DEX     = 8'hCA;
    localparam logic [7:0] OP_DEY     = 8'h88;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    typedef enum logic [2:0] {
        RESET_LO,
        RESET_HI,
        FETCH,
        OPERAND,
        ADDR_HI,
        ZP_READ,
        ZP_WRITE
`ifdef CPU_INDEXED_MODES_EN
        , INDEX
`endif
    } state_t;

    function automatic logic is_imm(input logic [7:0] op);
        return (op == OP_LDA_IMM) || (op == OP_LDX_IMM) || (op == OP_LDY_IMM) ||
               (op == OP_ADC_IMM) || (op == OP_SBC_IMM);
    endfunction

    function automatic logic is_zp_read(input logic [7:0] op);
        return (op == OP_LDA_ZP) || (op == OP_LDX_ZP) || (op == OP_LDY_ZP) || (op == OP_ADC_ZP);
    endfunction

    function automatic logic is_zp_write(input logic [7:0] op);
        return (op == OP_STA_ZP) || (op == OP_STX_ZP) || (op == OP_STY_ZP);
    endfunction

    function automatic logic is_indexed(input logic [7:0] op);
`ifdef CPU_INDEXED_MODES_EN
        return (op == OP_LDA_ZPX) || (op == OP_STA_ZPX) || (op == OP_LDX_ZPY);
`else
        return (op == 8'h00) && (op != 8'h00);
`endif
    endfunction

    // Anything that does not fetch an operand byte, including unknown opcodes, runs as a 2-tick implied op.
    function automatic logic needs_operand(input logic [7:0] op);
        return is_imm(op) || is_zp_read(op) || is_zp_write(op) || is_indexed(op) || (op == OP_JMP_ABS);
    endfunction

    function automatic logic [7:0] set_nz(input logic [7:0] p, input logic [7:0] v);
        logic [7:0] r;
        r         = p;
        r[FLAG_Z] = (v == 8'h00);
        r[FLAG_N] = v[7];
        return r;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - 8-bit binary adder with subtract, carry, overflow, zero and negative outputs
module cpu_alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    input  logic       subtract,
    output logic [7:0] result,
    output logic       carry,
    output logic       overflow,
    output logic       zero,
    output logic       negative
);

    logic [7:0] operand;
    logic [8:0] sum;

    // Subtraction is A + ~M + C, so overflow must look at the inverted operand actually fed to the adder.
    always_comb begin
        operand = subtract ? ~b : b;
        sum     = {1'b0, a} + {1'b0, operand} + {8'h00, carry_in};
    end

    assign result   = sum[7:0];
    assign carry    = sum[8];
    assign overflow = (a[7] == operand[7]) && (sum[7] != a[7]);
    assign zero     = (sum[7:0] == 8'h00);
    assign negative = sum[7];

endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - 6502-style core on a ticked byte bus; CPU_INDEXED_MODES_EN adds LDA zp,X / STA zp,X / LDX zp,Y
module cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned CLOCK_DIVIDER = 12,
    parameter logic [15:0] RESET_VECTOR  = 16'hFFFC,
    parameter logic [7:0]  RESET_STATUS  = 8'h34
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    output logic [7:0]  data_o,
    output logic [15:0] address_o,
    output logic        address_valid_o,
    output logic        data_valid_o,
    output logic [15:0] program_counter_o,
    output logic [7:0]  accumulator_o,
    output logic [7:0]  index_x_o,
    output logic [7:0]  index_y_o,
    output logic [7:0]  status_o,
    output logic        instruction_done_o
);

    localparam int unsigned DIV_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);

    state_t      state, state_next;
    logic [DIV_W-1:0] divider, divider_next;
    logic [15:0] pc, pc_next, address_q, address_next, retire_pc;
    logic [7:0]  acc, acc_next, idx_x, idx_x_next, idx_y, idx_y_next;
    logic [7:0]  status, status_next, opcode, opcode_next, operand, operand_next;
    logic [7:0]  data_q, data_next;
    logic        address_valid_q, address_valid_next, data_valid_q, data_valid_next;
    logic        done_q, done_next, tick, retire, load_en;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic        alu_cin, alu_sub, alu_carry, alu_overflow, alu_zero, alu_negative;

    assign tick = (divider == DIV_LAST);

    cpu_alu u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .carry_in (alu_cin),
        .subtract (alu_sub),
        .result   (alu_result),
        .carry    (alu_carry),
        .overflow (alu_overflow),
        .zero     (alu_zero),
        .negative (alu_negative)
    );

    // Increments/decrements are X/Y +/- 1; decrement is X + ~1 + 1.
    always_comb begin
        alu_a   = acc;
        alu_b   = data_i;
        alu_cin = status[FLAG_C];
        alu_sub = (opcode == OP_SBC_IMM);
        case (opcode)
            OP_INX:  begin alu_a = idx_x; alu_b = 8'h01; alu_cin = 1'b0; alu_sub = 1'b0; end
            OP_INY:  begin alu_a = idx_y; alu_b = 8'h01; alu_cin = 1'b0; alu_sub = 1'b0; end
            OP_DEX:  begin alu_a = idx_x; alu_b = 8'h01; alu_cin = 1'b1; alu_sub = 1'b1; end
            OP_DEY:  begin alu_a = idx_y; alu_b = 8'h01; alu_cin = 1'b1; alu_sub = 1'b1; end
            default: ;
        endcase
`ifdef CPU_INDEXED_MODES_EN
        if (state == INDEX) begin
            alu_a   = operand;
            alu_b   = (opcode == OP_LDX_ZPY) ? idx_y : idx_x;
            alu_cin = 1'b0;
            alu_sub = 1'b0;
        end
`endif
    end

    always_comb begin
        state_next         = state;
        divider_next       = tick ? '0 : divider + 1'b1;
        pc_next            = pc;
        acc_next           = acc;
        idx_x_next         = idx_x;
        idx_y_next         = idx_y;
        status_next        = status;
        opcode_next        = opcode;
        operand_next       = operand;
        address_next       = address_q;
        address_valid_next = address_valid_q;
        data_next          = data_q;
        data_valid_next    = data_valid_q;
        done_next          = 1'b0;
        retire             = 1'b0;
        retire_pc          = pc;
        load_en            = 1'b0;

        if (tick) begin
            case (state)
                RESET_LO: if (data_valid_i) begin
                    pc_next[7:0] = data_i;
                    address_next = RESET_VECTOR + 16'd1;
                    state_next   = RESET_HI;
                end
                RESET_HI: if (data_valid_i) begin
                    pc_next[15:8] = data_i;
                    address_next  = {data_i, pc[7:0]};
                    state_next    = FETCH;
                end
                FETCH: if (data_valid_i) begin
                    opcode_next = data_i;
                    state_next  = OPERAND;
                    if (needs_operand(data_i)) address_next = pc + 16'd1;
                    else                       address_valid_next = 1'b0;
                end
                OPERAND: begin
                    if (!needs_operand(opcode)) begin
                        retire    = 1'b1;
                        retire_pc = pc + 16'd1;
                        case (opcode)
                            OP_TAX: begin idx_x_next = acc;   status_next = set_nz(status, acc);   end
                            OP_TAY: begin idx_y_next = acc;   status_next = set_nz(status, acc);   end
                            OP_TXA: begin acc_next   = idx_x; status_next = set_nz(status, idx_x); end
                            OP_TYA: begin acc_next   = idx_y; status_next = set_nz(status, idx_y); end
                            OP_INX, OP_DEX: begin
                                idx_x_next  = alu_result;
                                status_next = set_nz(status, alu_result);
                            end
                            OP_INY, OP_DEY: begin
                                idx_y_next  = alu_result;
                                status_next = set_nz(status, alu_result);
                            end
                            OP_CLC:  status_next[FLAG_C] = 1'b0;
                            OP_SEC:  status_next[FLAG_C] = 1'b1;
                            default: ;
                        endcase
                    end else if (data_valid_i) begin
                        operand_next = data_i;
                        if (is_imm(opcode)) begin
                            load_en   = 1'b1;
                            retire    = 1'b1;
                            retire_pc = pc + 16'd2;
                        end else if (is_zp_read(opcode)) begin
                            address_next = {8'h00, data_i};
                            state_next   = ZP_READ;
                        end else if (is_zp_write(opcode)) begin
                            address_next    = {8'h00, data_i};
                            data_next       = (opcode == OP_STX_ZP) ? idx_x :
                                              (opcode == OP_STY_ZP) ? idx_y : acc;
                            data_valid_next = 1'b1;
                            state_next      = ZP_WRITE;
                        end else if (opcode == OP_JMP_ABS) begin
                            address_next = pc + 16'd2;
                            state_next   = ADDR_HI;
                        end else begin
`ifdef CPU_INDEXED_MODES_EN
                            address_valid_next = 1'b0;
                            state_next         = INDEX;
`endif
                        end
                    end
                end
                ADDR_HI: if (data_valid_i) begin
                    retire    = 1'b1;
                    retire_pc = {data_i, operand};
                end
                ZP_READ: if (data_valid_i) begin
                    load_en   = 1'b1;
                    retire    = 1'b1;
                    retire_pc = pc + 16'd2;
                end
                ZP_WRITE: begin
                    data_valid_next = 1'b0;
                    retire          = 1'b1;
                    retire_pc       = pc + 16'd2;
                end
`ifdef CPU_INDEXED_MODES_EN
                INDEX: begin
                    address_next       = {8'h00, alu_result};
                    address_valid_next = 1'b1;
                    if (opcode == OP_STA_ZPX) begin
                        data_next       = acc;
                        data_valid_next = 1'b1;
                        state_next      = ZP_WRITE;
                    end else begin
                        state_next = ZP_READ;
                    end
                end
`endif
                default: state_next = FETCH;
            endcase
        end

        if (load_en) begin
            case (opcode)
                OP_LDA_IMM, OP_LDA_ZP, OP_LDA_ZPX: begin
                    acc_next    = data_i;
                    status_next = set_nz(status, data_i);
                end
                OP_LDX_IMM, OP_LDX_ZP, OP_LDX_ZPY: begin
                    idx_x_next  = data_i;
                    status_next = set_nz(status, data_i);
                end
                OP_LDY_IMM, OP_LDY_ZP: begin
                    idx_y_next  = data_i;
                    status_next = set_nz(status, data_i);
                end
                OP_ADC_IMM, OP_ADC_ZP, OP_SBC_IMM: begin
                    acc_next            = alu_result;
                    status_next[FLAG_C] = alu_carry;
                    status_next[FLAG_V] = alu_overflow;
                    status_next[FLAG_Z] = alu_zero;
                    status_next[FLAG_N] = alu_negative;
                end
                default: ;
            endcase
        end

        if (retire) begin
            pc_next            = retire_pc;
            address_next       = retire_pc;
            address_valid_next = 1'b1;
            state_next         = FETCH;
            done_next          = 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state           <= RESET_LO;
            divider         <= '0;
            pc              <= 16'h0000;
            acc             <= 8'h00;
            idx_x           <= 8'h00;
            idx_y           <= 8'h00;
            status          <= RESET_STATUS;
            opcode          <= 8'h00;
            operand         <= 8'h00;
            address_q       <= RESET_VECTOR;
            address_valid_q <= 1'b1;
            data_q          <= 8'h00;
            data_valid_q    <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state           <= state_next;
            divider         <= divider_next;
            pc              <= pc_next;
            acc             <= acc_next;
            idx_x           <= idx_x_next;
            idx_y           <= idx_y_next;
            status          <= status_next;
            opcode          <= opcode_next;
            operand         <= operand_next;
            address_q       <= address_next;
            address_valid_q <= address_valid_next;
            data_q          <= data_next;
            data_valid_q    <= data_valid_next;
            done_q          <= done_next;
        end
    end

    assign data_o             = data_q;
    assign address_o          = address_q;
    assign address_valid_o    = address_valid_q;
    assign data_valid_o       = data_valid_q;
    assign program_counter_o  = pc;
    assign accumulator_o      = acc;
    assign index_x_o          = idx_x;
    assign index_y_o          = idx_y;
    assign status_o           = status;
    assign instruction_done_o = done_q;

endmodule
